// File: rtl/dlx_fetch_pkg.sv
// dlx_fetch_pkg: shared types and constants for the DLX instruction prefetch queue.
package dlx_fetch_pkg;
  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {IDLE, FETCH, FULL, SQUASH} state_t;
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH-entry circular buffer of {pc, data} with wrap-bit pointers and sync flush.
module instr_fifo import dlx_fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  entry_t                   wr_data,
  input  logic                     rd_en,
  output entry_t                   rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign rd_data = mem[rptr[AW-1:0]];
  assign empty = wptr == rptr;
  assign count = wptr - rptr;
  always_ff @(posedge clk)
    if (wr_en && !flush) mem[wptr[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: PC walker + req/ack fetch FSM feeding a decode-side queue.
// Optional PREFETCH_PERF_EN adds fetch/flush event counters.
module instr_prefetch_queue import dlx_fetch_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state;
  logic [31:0] tgt, rpc;
  logic [CW-1:0] cnt, cnt_nxt;
  logic enq, deq, empty;
  entry_t head, wdata;
  assign rpc = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req = state == FETCH || state == SQUASH;
  assign enq = state == FETCH && imem_ack && !redirect_valid;
  assign deq = inst_valid && inst_ready && !redirect_valid;
  assign cnt_nxt = cnt + CW'(enq) - CW'(deq);
  assign wdata = '{pc: imem_addr, data: imem_rdata};
  assign inst_valid = !empty;
  assign inst_data = empty ? '0 : head.data;
  assign inst_pc = empty ? '0 : head.pc;
  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(redirect_valid),
    .wr_en(enq), .wr_data(wdata), .rd_en(deq),
    .rd_data(head), .empty(empty), .count(cnt)
  );
  // In SQUASH imem_addr stays on the abandoned request while tgt holds the redirect target.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      imem_addr <= RESET_PC;
      tgt <= RESET_PC;
    end else if (redirect_valid) begin
      if (imem_req && !imem_ack) begin
        state <= SQUASH;
        tgt <= rpc;
      end else begin
        state <= FETCH;
        imem_addr <= rpc;
      end
    end else if (state == IDLE) state <= FETCH;
    else if (state == FETCH && imem_ack) begin
      imem_addr <= imem_addr + PC_STEP;
      state <= cnt_nxt == CW'(DEPTH) ? FULL : FETCH;
    end else if (state == FULL && deq) state <= FETCH;
    else if (state == SQUASH && imem_ack) begin
      state <= FETCH;
      imem_addr <= tgt;
    end
`ifdef PREFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(enq);
      perf_flush_cnt <= perf_flush_cnt + 32'(redirect_valid);
    end
`endif
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: queue-level reference model plus directed scenarios for the prefetch queue.
module tb_instr_prefetch_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 1;
  logic imem_req, imem_ack, inst_valid, inst_ready, redirect_valid;
  logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc, redirect_pc;
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  assign imem_rdata = mem_f(imem_addr);

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef PREFETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: queue contents, next fetch address and squash bookkeeping.
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
  ent_t mq[$];
  bit started, sq, m_req, m_deq;
  logic [31:0] m_pc, sq_addr;
  int m_fetches, m_flushes;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      started = 0;
      sq = 0;
      m_pc = 32'h0;
      sq_addr = 32'h0;
      m_fetches = 0;
      m_flushes = 0;
    end else begin
      m_req = started && (sq || mq.size() < DEPTH);
      m_deq = mq.size() > 0 && inst_ready;
      if (redirect_valid) m_flushes++;
      if (!started) begin
        started = 1;
        if (redirect_valid) m_pc = redirect_pc & ~32'h3;
      end else if (redirect_valid) begin
        mq.delete();
        if (m_req && !imem_ack) begin
          if (!sq) sq_addr = m_pc;
          sq = 1;
        end else sq = 0;
        m_pc = redirect_pc & ~32'h3;
      end else begin
        if (m_deq) void'(mq.pop_front());
        if (m_req && imem_ack) begin
          if (sq) sq = 0;
          else begin
            mq.push_back('{m_pc, mem_f(m_pc)});
            m_pc += 32'd4;
            m_fetches++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_req", {31'b0, imem_req}, {31'b0, started && (sq || mq.size() < DEPTH)});
      if (started && (sq || mq.size() < DEPTH)) chk("m_addr", imem_addr, sq ? sq_addr : m_pc);
      chk("m_valid", {31'b0, inst_valid}, {31'b0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk("m_pc", inst_pc, mq[0].pc);
        chk("m_data", inst_data, mq[0].data);
      end
`ifdef PREFETCH_PERF_EN
      chk("m_perf_fetch", perf_fetch_cnt, m_fetches);
      chk("m_perf_flush", perf_flush_cnt, m_flushes);
`endif
    end
  end

  task automatic do_reset(input logic a, input logic r);
    @(negedge clk);
    #2 rst_n = 0;
    imem_ack = a;
    inst_ready = r;
    redirect_valid = 0;
    redirect_pc = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    imem_ack = 1;
    inst_ready = 1;
    redirect_valid = 0;
    redirect_pc = 0;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst req", {31'b0, imem_req}, 0);
    chk("rst addr", imem_addr, 32'h0);
    chk("rst valid", {31'b0, inst_valid}, 0);
    chk("rst data", inst_data, 0);
    chk("rst pc", inst_pc, 0);
    rst_n = 1;
    // streaming with ack tied high
    @(negedge clk);
    chk("t1 req", {31'b0, imem_req}, 1);
    chk("t1 addr0", imem_addr, 32'h0);
    @(negedge clk);
    chk("t1 valid", {31'b0, inst_valid}, 1);
    chk("t1 pc0", inst_pc, 32'h0);
    chk("t1 addr4", imem_addr, 32'h4);
    @(negedge clk);
    chk("t1 pc4", inst_pc, 32'h4);
    chk("t1 addr8", imem_addr, 32'h8);
    repeat (3) @(negedge clk);
    // fill to full with decode stalled, then free one slot
    do_reset(1, 0);
    @(negedge clk);
    chk("t2 addr0", imem_addr, 32'h0);
    repeat (4) @(negedge clk);
    chk("t2 full req", {31'b0, imem_req}, 0);
    chk("t2 head", inst_pc, 32'h0);
    @(negedge clk);
    chk("t2 full req2", {31'b0, imem_req}, 0);
    inst_ready = 1;
    @(negedge clk);
    chk("t2 rereq", {31'b0, imem_req}, 1);
    chk("t2 addr16", imem_addr, 32'h10);
    chk("t2 head4", inst_pc, 32'h4);
    inst_ready = 0;
    repeat (3) @(negedge clk);
    // redirect while a slow request is outstanding
    do_reset(0, 1);
    @(negedge clk);
    chk("t3 addr0", imem_addr, 32'h0);
    redirect_valid = 1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 0;
    chk("t3 hold1", imem_addr, 32'h0);
    @(negedge clk);
    chk("t3 hold2", imem_addr, 32'h0);
    @(negedge clk);
    chk("t3 hold3", imem_addr, 32'h0);
    chk("t3 req", {31'b0, imem_req}, 1);
    imem_ack = 1;
    @(negedge clk);
    chk("t3 newaddr", imem_addr, 32'h100);
    chk("t3 novalid", {31'b0, inst_valid}, 0);
    @(negedge clk);
    chk("t3 pc", inst_pc, 32'h100);
    chk("t3 data", inst_data, mem_f(32'h100));
    // redirect coinciding with ack and a dequeue
    do_reset(1, 1);
    repeat (3) @(negedge clk);
    chk("t4 pc4", inst_pc, 32'h4);
    redirect_valid = 1;
    redirect_pc = 32'h203;
    @(negedge clk);
    redirect_valid = 0;
    chk("t4 flushed", {31'b0, inst_valid}, 0);
    chk("t4 addr", imem_addr, 32'h200);
    @(negedge clk);
    chk("t4 pc", inst_pc, 32'h200);
    // address wrap at the top of memory
    do_reset(1, 1);
    @(negedge clk);
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 0;
    chk("t5 a0", imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("t5 a1", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t5 a2", imem_addr, 32'h0);
    chk("t5 pc1", inst_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t5 pc2", inst_pc, 32'h0);
    // event counters over a run with two redirects, then async reset
    do_reset(1, 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      redirect_valid = (k == 3 || k == 6);
      redirect_pc = (k == 3) ? 32'h40 : 32'h80;
    end
    @(negedge clk);
`ifdef PREFETCH_PERF_EN
    chk("t6 fetches", perf_fetch_cnt, 10);
    chk("t6 flushes", perf_flush_cnt, 2);
`endif
    chk("t6 valid pre", {31'b0, inst_valid}, 1);
    #2 rst_n = 0;
    #1;
    chk("t6 rst req", {31'b0, imem_req}, 0);
    chk("t6 rst valid", {31'b0, inst_valid}, 0);
    chk("t6 rst data", inst_data, 0);
    chk("t6 rst pc", inst_pc, 0);
    chk("t6 rst addr", imem_addr, 32'h0);
`ifdef PREFETCH_PERF_EN
    chk("t6 rst pf", perf_fetch_cnt, 0);
    chk("t6 rst pfl", perf_flush_cnt, 0);
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
